// File: rtl/uart_tx_fifo.sv
// Burst-absorbing word FIFO in front of UART_TX: stores pushes and hands words
// to the transmitter one at a time over the data_ready/data/data_sent handshake.
module uart_tx_fifo #(
  parameter int unsigned BITS  = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [BITS-1:0] wr_data,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count,
  output logic            overflow,
  output logic [BITS-1:0] tx_data,
  output logic            tx_data_ready,
  input  logic            tx_data_sent
);

  localparam int unsigned CW = AW + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wp;
  logic [AW-1:0]   r_rp;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            r_full;
  logic            r_empty;
  logic            r_overflow;
  logic [BITS-1:0] r_tx_data;
  logic            w_pop;
  logic            w_push;

  // Drain FSM: pop only from IDLE so ready always drops for a cycle between words.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_data_sent) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign w_push = wr_en && (!r_full || w_pop);

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == CW'(DEPTH));
      r_empty    <= (w_count_nxt == '0);
      r_overflow <= wr_en && r_full && !w_pop;
      if (w_push) begin
        r_wp <= r_wp + AW'(1);
      end
      if (w_pop) begin
        r_tx_data <= r_mem[r_rp];
        r_rp      <= r_rp + AW'(1);
      end
    end
  end

  assign full          = r_full;
  assign empty         = r_empty;
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign tx_data       = r_tx_data;
  assign tx_data_ready = (r_state == ST_SEND);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed pushes feed a scoreboard queue; a transmitter
// model pops and compares each word the FIFO presents.
module tb_uart_tx_fifo;

  localparam int unsigned BITS  = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic            clk;
  logic            rst;
  logic            wr_en;
  logic [BITS-1:0] wr_data;
  logic            full;
  logic            empty;
  logic [AW:0]     count;
  logic            overflow;
  logic [BITS-1:0] tx_data;
  logic            tx_data_ready;
  logic            tx_data_sent;

  uart_tx_fifo #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_data       (wr_data),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .overflow      (overflow),
    .tx_data       (tx_data),
    .tx_data_ready (tx_data_ready),
    .tx_data_sent  (tx_data_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [BITS-1:0] q[$];

  // Transmitter model state
  logic            m_en     = 1'b0;
  logic            m_sent   = 1'b0;
  logic            man_sent = 1'b0;
  int              m_st     = 0;
  int              m_cnt    = 0;
  int              m_frame  = 4;
  logic [BITS-1:0] m_word   = '0;

  assign tx_data_sent = m_sent | man_sent;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Level-sensitive transmitter: takes the word while ready, holds for a frame, pulses sent.
  always @(negedge clk) begin
    case (m_st)
      0: begin
        if (m_en && tx_data_ready) begin
          check("rx_expected_word", 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) check("rx_data", 32'(tx_data), 32'(q.pop_front()));
          m_word = tx_data;
          m_cnt  = m_frame;
          m_st   = 1;
        end
      end
      1: begin
        if (tx_data !== m_word || tx_data_ready !== 1'b1)
          check("tx_hold", 32'({tx_data_ready, tx_data}), 32'({1'b1, m_word}));
        if (m_cnt == 0) begin
          m_sent = 1'b1;
          m_st   = 2;
        end else begin
          m_cnt--;
        end
      end
      default: begin
        m_sent = 1'b0;
        check("ready_drop", 32'(tx_data_ready), 32'd0);
        m_st = 0;
      end
    endcase
  end

  task automatic push_word(input logic [BITS-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_drained();
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && empty && !tx_data_ready && m_st == 0) break;
    end
    check("drain_timeout", 32'(i < 3000), 32'd1);
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(tx_data_ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);

    // Reset while a word is held at the transmitter
    wr_en = 1'b1; wr_data = 8'h55;
    @(negedge clk);
    wr_en = 1'b0;
    check("push_empty0", 32'(empty), 32'd0);
    check("push_count1", 32'(count), 32'd1);
    check("push_ready0", 32'(tx_data_ready), 32'd0);
    @(negedge clk);
    check("lat_ready1", 32'(tx_data_ready), 32'd1);
    check("lat_data", 32'(tx_data), 32'h55);
    check("lat_empty", 32'(empty), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ready", 32'(tx_data_ready), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_tx_data", 32'(tx_data), 32'd0);

    // Single word end-to-end
    m_en = 1'b1;
    push_word(8'h55);
    wr_en = 1'b0;
    @(negedge clk);
    check("single_ready", 32'(tx_data_ready), 32'd1);
    wait_drained();

    // Burst of 16 on consecutive cycles against a slow transmitter
    m_frame = 20;
    for (int i = 1; i <= 16; i++) begin
      push_word(BITS'(i));
      check("burst_no_ovf", 32'(overflow), 32'd0);
    end
    wr_en = 1'b0;
    check("burst_count", 32'(count), 32'd15);
    check("burst_full", 32'(full), 32'd0);
    @(negedge clk);
    check("burst_no_ovf_end", 32'(overflow), 32'd0);
    wait_drained();

    // Fill storage with one word held at TX, then overflow
    m_en    = 1'b0;
    m_frame = 4;
    for (int i = 0; i < 17; i++) push_word(BITS'(8'h30 + i));
    wr_en = 1'b0;
    check("fill_count", 32'(count), 32'd16);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ready", 32'(tx_data_ready), 32'd1);
    wr_en = 1'b1; wr_data = 8'hAA;
    @(negedge clk);
    wr_en = 1'b0;
    check("ovf_pulse", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    @(negedge clk);
    check("ovf_one_cycle", 32'(overflow), 32'd0);

    // Complete the held word by hand, then push exactly on the pop edge
    check("held_word", 32'(tx_data), 32'(q[0]));
    void'(q.pop_front());
    man_sent = 1'b1;
    @(negedge clk);
    man_sent = 1'b0;
    check("man_ready_drop", 32'(tx_data_ready), 32'd0);
    check("man_count", 32'(count), 32'd16);
    wr_en = 1'b1; wr_data = 8'hCC;
    q.push_back(8'hCC);
    @(negedge clk);
    wr_en = 1'b0;
    check("pp_no_ovf", 32'(overflow), 32'd0);
    check("pp_count", 32'(count), 32'd16);
    check("pp_full", 32'(full), 32'd1);
    check("pp_ready", 32'(tx_data_ready), 32'd1);
    check("pp_next_word", 32'(tx_data), 32'(q[0]));
    m_en = 1'b1;
    wait_drained();

    // Pointer wrap: 40 words in groups of 5
    for (int g = 0; g < 8; g++) begin
      for (int k = 0; k < 5; k++) push_word(BITS'(g * 5 + k));
      wr_en = 1'b0;
      wait_drained();
    end
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_count", 32'(count), 32'd0);
    check("wrap_overflow", 32'(overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
